bs_acc_deser: RTL and testbench
===============================

// Module: bs_acc_deser
// PURPOSE
//   Downstream stage of the bit-serial multiplier. Consumes its serial product stream (LSB first, framed by
//   firstbit/lastbit), accumulates ACC_LEN consecutive products bit-serially (one full adder + carry flop), and
//   presents the WIDTH-bit two's-complement sum as a parallel word with a valid/ready handshake and status flags.
// PARAMETERS
//   WIDTH    16  product and accumulator word width in bits (>= 4)
//   ACC_LEN  4   products summed per result (>= 1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   p          in   1      serial product bit, LSB first, one bit per cycle
//   firstbit   in   1      high in the cycle p carries bit 0 of a product
//   lastbit    in   1      high in the cycle p carries bit WIDTH-1 of a product
//   acc_out    out  WIDTH  accumulated sum (two's complement, wraps mod 2^WIDTH)
//   acc_valid  out  1      acc_out/acc_ovf valid; held until accepted
//   acc_ready  in   1      consumer accepts when acc_valid && acc_ready at clk edge
//   acc_ovf    out  1      signed overflow occurred in any add of this result
//   overrun    out  1      sticky: result lost to backpressure; cleared only by rst
//   frame_err  out  1      sticky: framing violation seen; cleared only by rst
// BEHAVIOUR
//   Reset: all outputs 0; acc_sr=0, carry=0, bit_cnt=0, word_cnt=0, state IDLE.
//   Adder: s = p ^ acc_sr[0] ^ c_eff; c_eff = 0 when firstbit else carry; carry <= maj(p, acc_sr[0], c_eff);
//     acc_sr shifts right, s enters bit WIDTH-1. After WIDTH cycles acc_sr = old + product mod 2^WIDTH.
//   Overflow: in the lastbit cycle, c_eff != carry-out -> word ovf; OR-ed into ovf_acc for this result.
//   States: IDLE  - waits for firstbit; p ignored otherwise. firstbit -> ACCUM, bit_cnt=1 after edge.
//           ACCUM - one bit per cycle, bit_cnt++ each cycle.
//             lastbit with bit_cnt==WIDTH-1: word done, word_cnt++, bit_cnt=0.
//               If word_cnt reaches ACC_LEN: latch sum and ovf_acc to acc_out/acc_ovf, assert acc_valid next
//               cycle (latency 1 after final lastbit); clear acc_sr, ovf_acc, word_cnt.
//             Then -> IDLE, or directly to ACCUM if firstbit is high the very next cycle (back-to-back, no gap).
//   Back-to-back words: firstbit may follow lastbit immediately; no bubble cycle required.
//   Output side is double-buffered: accumulation continues while acc_valid is high.
//     acc_valid drops the cycle after acceptance unless a new result is latched that same edge (stays 1).
//     New result ready while acc_valid && !acc_ready: new result overwrites acc_out, overrun <= 1.
//   Framing errors (frame_err <= 1; acc_sr, carry, word_cnt, ovf_acc cleared; partial sum discarded):
//     - firstbit in ACCUM with bit_cnt != 0: error, and this cycle starts a new word (state ACCUM, bit_cnt=1).
//     - lastbit with bit_cnt != WIDTH-1, or lastbit in IDLE: error, state -> IDLE.
//     - bit_cnt == WIDTH-1 without lastbit: error, state -> IDLE.
//     - firstbit and lastbit together: error (WIDTH >= 4), -> IDLE.
//   Pending acc_out/acc_valid are unaffected by framing errors.
//   Reset mid-word or mid-handshake: immediate return to reset values; acc_valid falls asynchronously.
// TESTING
//   1 ACC_LEN=4, products 3,5,7,9 back-to-back, acc_ready=1 -> acc_out=24, acc_valid 1 cycle, acc_ovf=0.
//   2 Signed: -2 (0xFFFE), 1, -3 (0xFFFD), 4 -> acc_out=0x0000, acc_ovf=0.
//   3 Overflow: 0x7FFF, 1, 0, 0 -> acc_out=0x8000, acc_ovf=1; next result 1,1,1,1 -> 4, acc_ovf=0.
//   4 Backpressure: acc_ready=0, two results (10, then 20) -> acc_out=20, overrun=1; then ready -> valid drops.
//   5 Framing: lastbit at bit 7 of word 2 -> frame_err=1, no result; next 4 clean words of 1 -> acc_out=4.
//   6 rst pulsed at bit 8 of word 3 -> all outputs 0 at once; next 4 words of 2 -> acc_out=8, frame_err=0.

Source files
------------

// File: rtl/bs_acc_deser.sv
// Bit-serial accumulator and deserializer.
// Takes the serial product stream (LSB first, framed by firstbit/lastbit) and adds
// ACC_LEN consecutive products. The adder is one full adder plus a carry flop.
// The WIDTH-bit sum is then presented as a parallel word with a valid/ready
// handshake. Sticky flags report lost results (overrun) and framing violations.
module bs_acc_deser #(
    parameter int WIDTH   = 16,
    parameter int ACC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p,
    input  logic             firstbit,
    input  logic             lastbit,
    output logic [WIDTH-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_ovf,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int WW = $clog2(ACC_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(ACC_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic [WW-1:0]    word_cnt;
    logic             ovf_acc;

    logic             c_eff;
    logic             sum_bit;
    logic             cout;
    logic             word_ovf;
    logic [WIDTH-1:0] shifted;

    // Full adder on the accumulator LSB; the carry chain restarts on every firstbit
    always_comb begin
        c_eff    = firstbit ? 1'b0 : carry;
        sum_bit  = p ^ acc_sr[0] ^ c_eff;
        cout     = (p & acc_sr[0]) | (p & c_eff) | (acc_sr[0] & c_eff);
        word_ovf = c_eff ^ cout;
        shifted  = {sum_bit, acc_sr[WIDTH-1:1]};
    end

    // Framing FSM, serial accumulation and the double-buffered output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_sr    <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            ovf_acc   <= 1'b0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            acc_ovf   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // An accepted result is dropped. A result latched below on this same edge overrides this.
            if (acc_valid && acc_ready)
                acc_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (lastbit) begin
                        // A lastbit with no word in progress is a framing error
                        frame_err <= 1'b1;
                        acc_sr    <= '0;
                        carry     <= 1'b0;
                        word_cnt  <= '0;
                        ovf_acc   <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (firstbit) begin
                        acc_sr  <= shifted;
                        carry   <= cout;
                        bit_cnt <= CW'(1);
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (firstbit && !lastbit) begin
                        // The word in progress is cut short. Drop the partial sum and start a fresh word with this bit.
                        frame_err <= 1'b1;
                        acc_sr    <= {p, {(WIDTH-1){1'b0}}};
                        carry     <= 1'b0;
                        word_cnt  <= '0;
                        ovf_acc   <= 1'b0;
                        bit_cnt   <= CW'(1);
                    end else if (firstbit || (lastbit != (bit_cnt == LAST_BIT))) begin
                        // This covers a misplaced or missing lastbit, and firstbit together with lastbit
                        frame_err <= 1'b1;
                        acc_sr    <= '0;
                        carry     <= 1'b0;
                        word_cnt  <= '0;
                        ovf_acc   <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (lastbit) begin
                        bit_cnt <= '0;
                        carry   <= 1'b0;
                        state   <= IDLE;
                        if (word_cnt == LAST_WORD) begin
                            acc_out   <= shifted;
                            acc_ovf   <= ovf_acc | word_ovf;
                            acc_valid <= 1'b1;
                            if (acc_valid && !acc_ready)
                                overrun <= 1'b1;
                            acc_sr    <= '0;
                            ovf_acc   <= 1'b0;
                            word_cnt  <= '0;
                        end else begin
                            acc_sr   <= shifted;
                            ovf_acc  <= ovf_acc | word_ovf;
                            word_cnt <= word_cnt + WW'(1);
                        end
                    end else begin
                        acc_sr  <= shifted;
                        carry   <= cout;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_acc_deser.sv
// Testbench for bs_acc_deser: table vectors, randomized results against a signed
// arithmetic model, and hand-written backpressure, framing and reset sequences.
module tb_bs_acc_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic        p, firstbit, lastbit, acc_ready;
    logic [15:0] acc_out;
    logic        acc_valid, acc_ovf, overrun, frame_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bs_acc_deser #(.WIDTH(16), .ACC_LEN(4)) dut (
        .clk(clk), .rst(rst), .p(p), .firstbit(firstbit), .lastbit(lastbit),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_ovf(acc_ovf), .overrun(overrun), .frame_err(frame_err)
    );

    typedef struct {
        logic [3:0][15:0] w;
        logic [15:0]      exp_sum;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0h expected %0h ok", name, got, exp);
        end else begin
            $display("FAIL %-14s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one serial cycle; the task returns 1 time unit after the active edge
    task automatic send_bit(input logic b, input logic f, input logic l);
        p = b; firstbit = f; lastbit = l;
        @(posedge clk);
        #1;
        p = 1'b0; firstbit = 1'b0; lastbit = 1'b0;
    endtask

    // Send bits 0..last_pos of v, with lastbit on bit last_pos (15 for a clean word)
    task automatic send_word(input logic [15:0] v, input int last_pos);
        for (int i = 0; i <= last_pos; i++)
            send_bit(v[i], i == 0, i == last_pos);
    endtask

    task automatic idle_cycle();
        send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    logic [15:0] m_acc;
    logic        m_ovf;
    logic [15:0] rw;
    int          t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{w: {16'd9, 16'd7, 16'd5, 16'd3},                  exp_sum: 16'd24,    exp_ovf: 1'b0};
        vecs[1] = '{w: {16'd4, 16'hFFFD, 16'd1, 16'hFFFE},            exp_sum: 16'h0000,  exp_ovf: 1'b0};
        vecs[2] = '{w: {16'd0, 16'd0, 16'd1, 16'h7FFF},               exp_sum: 16'h8000,  exp_ovf: 1'b1};
        vecs[3] = '{w: {16'd1, 16'd1, 16'd1, 16'd1},                  exp_sum: 16'd4,     exp_ovf: 1'b0};
        vecs[4] = '{w: {16'd1, 16'd0, 16'hFFFF, 16'h8000},            exp_sum: 16'h8000,  exp_ovf: 1'b1};

        rst = 1'b1; p = 1'b0; firstbit = 1'b0; lastbit = 1'b0; acc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, acc_valid}, 0);
        chk("rst_out", {16'b0, acc_out}, 0);
        chk("rst_flags", {29'b0, acc_ovf, overrun, frame_err}, 0);
        rst = 1'b0;
        idle_cycle();

        // Table vectors: four back-to-back words, then the result one cycle after the final lastbit
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++)
                send_word(vecs[v].w[k], 15);
            chk($sformatf("tab%0d_valid", v), {31'b0, acc_valid}, 1);
            chk($sformatf("tab%0d_out", v), {16'b0, acc_out}, {16'b0, vecs[v].exp_sum});
            chk($sformatf("tab%0d_ovf", v), {31'b0, acc_ovf}, {31'b0, vecs[v].exp_ovf});
            idle_cycle();
            chk($sformatf("tab%0d_drop", v), {31'b0, acc_valid}, 0);
        end

        // Random results with random idle gaps, checked against signed arithmetic
        for (int r = 0; r < 8; r++) begin
            m_acc = '0; m_ovf = 1'b0;
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                rw = 16'($urandom);
                if (r % 2 == 1) rw = {{4{rw[15]}}, rw[11:0]};
                t = int'($signed(m_acc)) + int'($signed(rw));
                if (t > 32767 || t < -32768) m_ovf = 1'b1;
                m_acc = t[15:0];
                send_word(rw, 15);
            end
            chk($sformatf("rnd%0d_valid", r), {31'b0, acc_valid}, 1);
            chk($sformatf("rnd%0d_out", r), {16'b0, acc_out}, {16'b0, m_acc});
            chk($sformatf("rnd%0d_ovf", r), {31'b0, acc_ovf}, {31'b0, m_ovf});
        end
        idle_cycle();

        // Backpressure: a second result overwrites an unaccepted one
        acc_ready = 1'b0;
        send_word(16'd1, 15); send_word(16'd2, 15); send_word(16'd3, 15); send_word(16'd4, 15);
        chk("bp_first_out", {16'b0, acc_out}, 10);
        chk("bp_first_ovr", {31'b0, overrun}, 0);
        idle_cycle();
        chk("bp_hold", {31'b0, acc_valid}, 1);
        for (int k = 0; k < 4; k++) send_word(16'd5, 15);
        chk("bp_second_out", {16'b0, acc_out}, 20);
        chk("bp_overrun", {31'b0, overrun}, 1);
        chk("bp_valid", {31'b0, acc_valid}, 1);
        acc_ready = 1'b1;
        idle_cycle();
        chk("bp_drop", {31'b0, acc_valid}, 0);

        // Framing: lastbit on bit 7 of word 2
        send_word(16'd1, 15);
        send_word(16'd1, 7);
        chk("fr_err", {31'b0, frame_err}, 1);
        chk("fr_noresult", {31'b0, acc_valid}, 0);
        for (int k = 0; k < 4; k++) send_word(16'd1, 15);
        chk("fr_recover", {16'b0, acc_out}, 4);
        chk("fr_recov_vld", {31'b0, acc_valid}, 1);
        idle_cycle();

        // Reset mid-word with a result still pending
        acc_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(16'd3, 15);
        chk("rs_pending", {16'b0, acc_out}, 12);
        send_word(16'd2, 15); send_word(16'd2, 15);
        rw = 16'd2;
        for (int i = 0; i < 8; i++) send_bit(rw[i], i == 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rs_valid", {31'b0, acc_valid}, 0);
        chk("rs_out", {16'b0, acc_out}, 0);
        chk("rs_flags", {29'b0, acc_ovf, overrun, frame_err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_word(16'd2, 15);
        chk("rs_result", {16'b0, acc_out}, 8);
        chk("rs_ferr", {31'b0, frame_err}, 0);
        chk("rs_ovr", {31'b0, overrun}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
